// File: rtl/shift_pkg.sv
// Shared types for the parametrised shift register: shift modes and FSM states.
package shift_pkg;

  // One encoding per single-bit step behaviour; HOLD counts steps without moving data.
  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SRL  = 3'd1,
    SRA  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4,
    SIL  = 3'd5,
    SIR  = 3'd6,
    HOLD = 3'd7
  } shift_mode_t;

  // Controller states: waiting for a command, or stepping through a counted shift.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

endpackage : shift_pkg

// File: rtl/param_shift_reg_if.sv
// Command/status bundle of the shift register. The controller (master) drives
// load and start commands; the register (slave) returns contents and status.
interface param_shift_reg_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) ();

  logic              load_en;
  logic [WIDTH-1:0]  load_val;
  logic              start;
  shift_mode_t       mode;
  logic [AW-1:0]     amount;
  logic              serial_in;
  logic [WIDTH-1:0]  op;
  logic              serial_out;
  logic              busy;
  logic              done;

  modport master (
    output load_en, load_val, start, mode, amount, serial_in,
    input  op, serial_out, busy, done
  );

  modport slave (
    input  load_en, load_val, start, mode, amount, serial_in,
    output op, serial_out, busy, done
  );

endinterface : param_shift_reg_if

// File: rtl/shift_step.sv
// One single-bit step of the shift register: next word and the bit that leaves it.
// Purely combinational; the top level decides when to commit the result.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  shift_mode_t      mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] dout,
  output logic             bit_out
);

  // Select the next word and ejected bit for the requested mode.
  always_comb begin
    dout    = din;
    bit_out = 1'b0;
    case (mode)
      SLL: begin
        dout    = {din[WIDTH-2:0], 1'b0};
        bit_out = din[WIDTH-1];
      end
      SRL: begin
        dout    = {1'b0, din[WIDTH-1:1]};
        bit_out = din[0];
      end
      SRA: begin
        dout    = {din[WIDTH-1], din[WIDTH-1:1]};
        bit_out = din[0];
      end
      ROL: begin
        dout    = {din[WIDTH-2:0], din[WIDTH-1]};
        bit_out = din[WIDTH-1];
      end
      ROR: begin
        dout    = {din[0], din[WIDTH-1:1]};
        bit_out = din[0];
      end
      SIL: begin
        dout    = {din[WIDTH-2:0], serial_in};
        bit_out = din[WIDTH-1];
      end
      SIR: begin
        dout    = {serial_in, din[WIDTH-1:1]};
        bit_out = din[0];
      end
      HOLD: begin
        dout    = din;
        bit_out = 1'b0;
      end
      default: begin
        dout    = din;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule : shift_step

// File: rtl/param_shift_reg.sv
// Multi-mode shift register with parallel load and a counted shift engine.
// A start command shifts the stored word by `amount` single-bit steps, one per
// clock; busy covers the stepping and done pulses for one cycle afterwards.
// Parallel load always wins over a running operation and aborts it silently.
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  param_shift_reg_if.slave  bus
);

  shift_state_t      state_r;
  shift_mode_t       mode_r;
  logic [AW-1:0]     cnt_r;
  logic [WIDTH-1:0]  op_r;
  logic              serial_out_r;
  logic              busy_r;
  logic              done_r;

  logic [WIDTH-1:0]  step_dout_s;
  logic              step_bit_s;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din       (op_r),
    .mode      (mode_r),
    .serial_in (bus.serial_in),
    .dout      (step_dout_s),
    .bit_out   (step_bit_s)
  );

  // Controller, step counter and output registers in one clocked process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      mode_r       <= SLL;
      cnt_r        <= '0;
      op_r         <= '0;
      serial_out_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (bus.load_en) begin
      // Load aborts whatever is running; serial_out keeps its last value.
      op_r    <= bus.load_val;
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (bus.amount == {AW{1'b0}}) begin
              // Zero-length command completes at once without stepping.
              done_r <= 1'b1;
            end else begin
              mode_r  <= bus.mode;
              cnt_r   <= bus.amount;
              busy_r  <= 1'b1;
              state_r <= SHIFT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          op_r  <= step_dout_s;
          cnt_r <= cnt_r - {{(AW-1){1'b0}}, 1'b1};
          if (mode_r != HOLD) begin
            serial_out_r <= step_bit_s;
          end else begin
            serial_out_r <= serial_out_r;
          end
          if (cnt_r == {{(AW-1){1'b0}}, 1'b1}) begin
            // Last step: leave busy and announce completion next cycle.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op         = op_r;
  assign bus.serial_out = serial_out_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule : param_shift_reg

// File: tb/tb_param_shift_reg.sv
// Randomised scoreboard bench for param_shift_reg at WIDTH=8 and WIDTH=16.
// Stimulus pushes the expected word, serial bit and done cycle; monitors pop on done.
module tb_param_shift_reg;
  import shift_pkg::*;

  typedef struct {
    logic [63:0] op;
    logic        so;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst16;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q8[$];
  exp_t q16[$];

  logic [63:0] cur8, cur16;
  logic        so8, so16;

  param_shift_reg_if #(.WIDTH(8))  bus8 ();
  param_shift_reg_if #(.WIDTH(16)) bus16 ();

  param_shift_reg #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst),   .bus(bus8));
  param_shift_reg #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: result of `a` single-bit steps, in closed form. Returns {so, word}.
  function automatic logic [64:0] model(input int w, input int m, input int a,
                                        input logic [63:0] v, input logic f,
                                        input logic so_prev);
    logic [63:0] mask, res;
    logic        so, s;
    int          r;
    mask = (64'h1 << w) - 64'h1;
    s    = v[w-1];
    r    = a % w;
    if (a == 0) return {so_prev, v};
    case (m)
      0: begin res = (a >= w) ? 64'h0 : ((v << a) & mask); so = (a <= w) ? v[w-a] : 1'b0; end
      1: begin res = (a >= w) ? 64'h0 : (v >> a);          so = (a <= w) ? v[a-1] : 1'b0; end
      2: begin
        res = (a >= w) ? (s ? mask : 64'h0) : ((v >> a) | (s ? (mask & ~(mask >> a)) : 64'h0));
        so  = (a <= w) ? v[a-1] : s;
      end
      3: begin res = ((v << r) | (v >> (w - r))) & mask; so = v[w-1-((a-1) % w)]; end
      4: begin res = ((v >> r) | (v << (w - r))) & mask; so = v[(a-1) % w]; end
      5: begin
        res = (a >= w) ? (f ? mask : 64'h0) : (((v << a) | (f ? ((64'h1 << a) - 64'h1) : 64'h0)) & mask);
        so  = (a <= w) ? v[w-a] : f;
      end
      6: begin
        res = (a >= w) ? (f ? mask : 64'h0) : ((v >> a) | (f ? (mask & ~(mask >> a)) : 64'h0));
        so  = (a <= w) ? v[a-1] : f;
      end
      default: begin res = v; so = so_prev; end
    endcase
    return {so, res};
  endfunction

  // Monitor for the 8-bit instance: every done pulse must match the next expectation.
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("op8", {56'h0, bus8.op}, e.op);
        chk("so8", {63'h0, bus8.serial_out}, {63'h0, e.so});
        chk("lat8", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (bus16.done === 1'b1) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("op16", {48'h0, bus16.op}, e.op);
        chk("so16", {63'h0, bus16.serial_out}, {63'h0, e.so});
        chk("lat16", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    bus8.load_en  = 1'b1;
    bus8.load_val = v;
    tick();
    bus8.load_en  = 1'b0;
    cur8 = {56'h0, v};
  endtask

  // Issue one counted operation on the 8-bit instance and wait until its done cycle.
  task automatic op8(input int m, input int amt, input logic f);
    logic [64:0] r;
    bus8.mode      = shift_mode_t'(m[2:0]);
    bus8.amount    = amt[3:0];
    bus8.serial_in = f;
    bus8.start     = 1'b1;
    tick();
    bus8.start     = 1'b0;
    r = model(8, m, amt, cur8, f, so8);
    q8.push_back('{op: r[63:0], so: r[64], cyc: cyc + amt});
    cur8 = r[63:0];
    so8  = r[64];
    for (int i = 0; i < amt; i++) begin
      chk("busy8_high", {63'h0, bus8.busy}, 64'd1);
      tick();
    end
    chk("busy8_low", {63'h0, bus8.busy}, 64'd0);
  endtask

  initial begin
    logic [64:0] r;
    rst = 1'b1; rst16 = 1'b1;
    bus8.load_en = 1'b1; bus8.load_val = 8'hA5; bus8.start = 1'b0;
    bus8.mode = SLL; bus8.amount = 4'd0; bus8.serial_in = 1'b0;
    bus16.load_en = 1'b1; bus16.load_val = 16'hFFFF; bus16.start = 1'b0;
    bus16.mode = SLL; bus16.amount = 5'd0; bus16.serial_in = 1'b0;
    tick(); tick();
    chk("rst_op8",   {56'h0, bus8.op}, 64'h0);
    chk("rst_busy8", {63'h0, bus8.busy}, 64'h0);
    chk("rst_done8", {63'h0, bus8.done}, 64'h0);
    chk("rst_so8",   {63'h0, bus8.serial_out}, 64'h0);
    chk("rst_op16",  {48'h0, bus16.op}, 64'h0);
    rst = 1'b0; rst16 = 1'b0;
    bus8.load_en = 1'b0; bus16.load_en = 1'b0;
    cur8 = 64'h0; so8 = 1'b0; cur16 = 64'h0; so16 = 1'b0;

    // Directed cases on WIDTH=8.
    load8(8'h55); op8(0, 3, 1'b0);
    load8(8'h80); op8(2, 2, 1'b0);
    load8(8'h01); op8(4, 1, 1'b0);
    op8(7, 4, 1'b0);
    load8(8'h81); op8(3, 8, 1'b0);
    load8(8'h00); op8(5, 4, 1'b1);
    load8(8'hC3); op8(0, 9, 1'b0);
    load8(8'h96); op8(6, 11, 1'b1);

    // Abort: load arrives on the second step edge, so only one step ran.
    load8(8'h6C);
    bus8.mode = SRL; bus8.amount = 4'd5; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.load_en = 1'b1; bus8.load_val = 8'hFF;
    tick();
    bus8.load_en = 1'b0;
    r = model(8, 1, 1, cur8, 1'b0, so8);
    so8 = r[64]; cur8 = 64'hFF;
    chk("abort_op8",   {56'h0, bus8.op}, 64'hFF);
    chk("abort_busy8", {63'h0, bus8.busy}, 64'h0);
    chk("abort_so8",   {63'h0, bus8.serial_out}, {63'h0, so8});
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone8", {63'h0, bus8.done}, 64'h0);
      tick();
    end

    // Zero amount: done on the next cycle, contents unchanged.
    op8(3, 0, 1'b0);

    // Start while busy is ignored; only the first command takes effect.
    load8(8'h3B);
    bus8.mode = SLL; bus8.amount = 4'd4; bus8.start = 1'b1;
    tick();
    r = model(8, 0, 4, cur8, 1'b0, so8);
    q8.push_back('{op: r[63:0], so: r[64], cyc: cyc + 4});
    cur8 = r[63:0]; so8 = r[64];
    bus8.mode = ROL; bus8.amount = 4'd1;
    tick(); tick();
    bus8.start = 1'b0;
    tick(); tick();
    chk("ign_busy8", {63'h0, bus8.busy}, 64'h0);

    // Randomised back-to-back operations with occasional loads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) load8(8'($urandom_range(0, 255)));
      op8(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=16: rotate by more than the width.
    bus16.load_en = 1'b1; bus16.load_val = 16'h8001;
    tick();
    bus16.load_en = 1'b0;
    cur16 = 64'h8001;
    bus16.mode = ROL; bus16.amount = 5'd17; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    r = model(16, 3, 17, cur16, 1'b0, so16);
    q16.push_back('{op: r[63:0], so: r[64], cyc: cyc + 17});
    cur16 = r[63:0]; so16 = r[64];
    for (int i = 0; i < 17; i++) tick();

    // Reset in the middle of a shift discards it without done.
    bus16.mode = SLL; bus16.amount = 5'd6; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tick(); tick();
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    chk("mrst_op16",   {48'h0, bus16.op}, 64'h0);
    chk("mrst_busy16", {63'h0, bus16.busy}, 64'h0);
    chk("mrst_done16", {63'h0, bus16.done}, 64'h0);
    chk("mrst_so16",   {63'h0, bus16.serial_out}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      chk("mrst_nodone16", {63'h0, bus16.done}, 64'h0);
      tick();
    end

    tick(); tick();
    chk("q8_drained",  q8.size(), 64'd0);
    chk("q16_drained", q16.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_param_shift_reg

// File: doc/param_shift_reg.md
# param_shift_reg

Parametrised multi-mode shift register with parallel load, serial in/out and a counted multi-cycle shift engine. It supersedes the fixed 8-bit left-shift register in the datapath exercises. One start command shifts the stored word by `amount` positions, one bit per clock, in any of seven modes. A busy/done handshake lets a controlling FSM or testbench sequence operations without counting cycles itself.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range is WIDTH ≥ 2.
- `AW`, default `$clog2(WIDTH)+1`: width of `amount`; must not be overridden.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_en`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  parallel load data.
- `start`  in  1  begin a counted shift.
- `mode`  in  3  shift mode, sampled with `start`.
- `amount`  in  AW  number of single-bit steps, sampled with `start`; range 0..2^AW-1.
- `serial_in`  in  1  fill bit for the SIL and SIR modes, sampled on every step.
- `op`  out  WIDTH  current register contents.
- `serial_out`  out  1  bit most recently shifted or rotated out.
- `busy`  out  1  a shift operation is in progress.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
Modes:
- 0 SLL: shift left, LSB filled with 0.
- 1 SRL: shift right, MSB filled with 0.
- 2 SRA: shift right, MSB replicated.
- 3 ROL: rotate left.
- 4 ROR: rotate right.
- 5 SIL: shift left, LSB filled from `serial_in`.
- 6 SIR: shift right, MSB filled from `serial_in`.
- 7 HOLD: counts the steps but leaves `op` and `serial_out` unchanged.

`serial_out` takes the bit that leaves the word on each step. For left modes this is the old MSB; for right modes it is the old LSB. Rotates also report the wrapped bit here.

State machine:
- IDLE → SHIFT: `start`=1, `load_en`=0, `amount`≠0. Latch `mode`; counter ← `amount`.
- IDLE → IDLE with `done` pulse: `start`=1, `amount`=0. `op` is unchanged.
- SHIFT: perform one step per cycle and decrement the counter. When the counter reaches 1, the step completes, the FSM returns to IDLE and `done` pulses.

Priority, highest first:
- `rst`: `op`=0, `serial_out`=0, `busy`=0, `done`=0, counter=0, state=IDLE.
- `load_en`: `op` ← `load_val`. In any state this aborts the operation: state → IDLE, `busy`=0, no `done` pulse. `serial_out` is unchanged.
- `start`: honoured only in IDLE; ignored while `busy`=1.
- Reset mid-operation discards the operation with no `done` pulse.

Boundaries:
- `amount` ≥ WIDTH is legal. Rotates wrap, so ROL by WIDTH returns the original word. Logical shifts saturate to 0.
- `start` asserted in the same cycle that `done` is high is accepted; back-to-back operations are allowed.

## Timing
- Start accepted at edge E0. Steps occur at edges E1..En, where n=`amount`.
- `busy` is 1 from after E0 through En, and falls after En.
- `done` is 1 for exactly the cycle after En.
- Total latency is `amount`+1 cycles from start to the `done` cycle. For `amount`=0, `done` is high for the cycle after E0 and `busy` never rises.
- Load is visible on `op` the cycle after the `load_en` edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `shift_pkg`:
  - `shift_mode_t` enum, 3 bits: SLL, SRL, SRA, ROL, ROR, SIL, SIR, HOLD.
  - `shift_state_t` enum: IDLE, SHIFT.
- Sub-module `shift_step`, purely combinational, parametrised by WIDTH.
  - Inputs: `din[WIDTH-1:0]`, `mode`, `serial_in`.
  - Outputs: `dout[WIDTH-1:0]`, `bit_out`.
  - The top level holds the FSM, counter and registers and instantiates one `shift_step`.

## Test plan
WIDTH=8 unless noted.
- Reset: `rst`=1 for 2 cycles with `load_en`=1 → `op`=0x00, `busy`=0, `done`=0; reset wins over load.
- SLL: load 0x55; start mode 0, amount 3 → after 3 cycles `op`=0xA8, `serial_out`=0; `done` pulses on cycle 4; `busy` high on cycles 1–3.
- SRA, ROR and HOLD:
  - Load 0x80; SRA amount 2 → `op`=0xE0, `serial_out`=0.
  - Load 0x01; ROR amount 1 → `op`=0x80, `serial_out`=1.
  - HOLD amount 4 → `op` unchanged; `done` on cycle 5.
- Wrap-around and serial fill:
  - Load 0x81; ROL amount 8 → `op`=0x81.
  - SIL amount 4 with `serial_in`=1 from 0x00 → `op`=0x0F.
  - SLL amount 9 → `op`=0x00.
- Abort, zero amount, ignored start:
  - Start SRL amount 5; assert `load_en` with 0xFF on step 2 → `op`=0xFF, `busy`=0, no `done`.
  - `amount`=0 → `done` on next cycle, `op` unchanged.
  - `start` while `busy`=1 → ignored.
- Parametric: WIDTH=16 with load 0x8001; ROL amount 17 → `op`=0x0003, `serial_out`=1. Then reset mid-SHIFT → all outputs 0, no `done`.
